// File: rtl/alu_scalar_div_module.sv
// Sequential signed divider: divides a 5x5 int8 matrix by a signed int8 scalar,
// one element at a time with an 8-step restoring divider on magnitudes.
module alu_scalar_div_module (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [199:0] A_flat,
  input  logic [7:0]   scalar,
  output logic [199:0] C_flat,
  output logic         busy,
  output logic         done,
  output logic         overflow_flag,
  output logic         div_zero_flag
);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_STORE, S_DONE} state_t;

  state_t       state_q, state_d;
  logic [199:0] a_q, a_d;
  logic [199:0] c_q, c_d;
  logic [7:0]   s_q, s_d;
  logic [7:0]   dvd_q, dvd_d;
  logic [7:0]   quo_q, quo_d;
  logic [8:0]   rem_q, rem_d;
  logic [4:0]   idx_q, idx_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         ovf_q, ovf_d;
  logic         dz_q, dz_d;

  logic [8:0]   shifted;
  logic [8:0]   dvsr;
  logic [7:0]   elem;
  logic [7:0]   nxt_elem;
  logic [4:0]   idx_nx;
  logic [7:0]   res_byte;

  // Unsigned magnitude; -128 maps to 128 (0x80) as an unsigned value.
  function automatic logic [7:0] mag8(input logic [7:0] v);
    return v[7] ? (~v + 8'd1) : v;
  endfunction

  function automatic logic [7:0] apply_sign(input logic [7:0] q, input logic neg);
    return neg ? (~q + 8'd1) : q;
  endfunction

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    c_d     = c_q;
    s_d     = s_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    dz_d    = dz_q;

    // idx_nx is clamped so the next-element select never leaves the matrix.
    idx_nx   = (idx_q == 5'd24) ? 5'd0 : idx_q + 5'd1;
    elem     = a_q[{idx_q, 3'b000} +: 8];
    nxt_elem = a_q[{idx_nx, 3'b000} +: 8];
    dvsr     = {1'b0, mag8(s_q)};
    shifted  = (rem_q << 1) | {8'h00, dvd_q[7]};
    res_byte = apply_sign(quo_q, elem[7] ^ s_q[7]);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d   = A_flat;
          s_d   = scalar;
          c_d   = '0;
          ovf_d = 1'b0;
          dz_d  = 1'b0;
          idx_d = 5'd0;
          if (scalar == 8'd0) begin
            dz_d    = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            dvd_d   = mag8(A_flat[7:0]);
            rem_d   = 9'd0;
            quo_d   = 8'd0;
            cnt_d   = 3'd0;
            busy_d  = 1'b1;
            state_d = S_DIV;
          end
        end
      end
      S_DIV: begin
        dvd_d = {dvd_q[6:0], 1'b0};
        if (shifted >= dvsr) begin
          rem_d = shifted - dvsr;
          quo_d = {quo_q[6:0], 1'b1};
        end else begin
          rem_d = shifted;
          quo_d = {quo_q[6:0], 1'b0};
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = S_STORE;
      end
      S_STORE: begin
        c_d[{idx_q, 3'b000} +: 8] = res_byte;
        // -128 / -1 naturally yields 0x80 here; only the sticky flag is extra.
        if (elem == 8'h80 && s_q == 8'hFF) ovf_d = 1'b1;
        if (idx_q == 5'd24) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_nx;
          dvd_d   = mag8(nxt_elem);
          rem_d   = 9'd0;
          quo_d   = 8'd0;
          cnt_d   = 3'd0;
          state_d = S_DIV;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      c_q     <= '0;
      s_q     <= '0;
      dvd_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      c_q     <= c_d;
      s_q     <= s_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign C_flat        = c_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign overflow_flag = ovf_q;
  assign div_zero_flag = dz_q;

endmodule

// File: tb/tb_alu_scalar_div_module.sv
// Directed bench for alu_scalar_div_module: hand-computed quotient matrices,
// handshake timing, flags, ignored start and asynchronous reset mid-run.
module tb_alu_scalar_div_module;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [199:0] A_flat;
  logic [7:0]   scalar;
  logic [199:0] C_flat;
  logic         busy;
  logic         done;
  logic         overflow_flag;
  logic         div_zero_flag;

  int passed = 0;
  int total  = 0;

  alu_scalar_div_module dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .A_flat       (A_flat),
    .scalar       (scalar),
    .C_flat       (C_flat),
    .busy         (busy),
    .done         (done),
    .overflow_flag(overflow_flag),
    .div_zero_flag(div_zero_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [199:0] fill(input logic [7:0] b);
    logic [199:0] v;
    for (int i = 0; i < 25; i++) v[i*8 +: 8] = b;
    return v;
  endfunction

  function automatic logic [199:0] rnd200();
    logic [199:0] v;
    for (int i = 0; i < 25; i++) v[i*8 +: 8] = 8'($urandom_range(0, 255));
    return v;
  endfunction

  // Pulses start (or holds it until done when hold=1), scrambles inputs after
  // acceptance, then tracks done/busy for 240 cycles. Cycle k is sampled #1
  // after the (k-1)th rising edge counted from the accepting edge.
  task automatic run_op(input string nm, input logic [199:0] a, input logic [7:0] s,
                        input bit hold, input logic [199:0] expc,
                        input logic expo, input logic expz);
    int dcyc, dcnt, bbad, expd;
    logic [199:0] cs;
    logic co, cz;
    logic exp_busy;
    cs = 'x; co = 1'bx; cz = 1'bx;
    dcyc = -1; dcnt = 0; bbad = 0;
    expd = (s == 8'd0) ? 1 : 226;
    @(negedge clk);
    A_flat = a; scalar = s; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    A_flat = ~a;
    scalar = s ^ 8'h5A;
    for (int cyc = 1; cyc <= 240; cyc++) begin
      exp_busy = (s != 8'd0) && (cyc <= 225);
      if (busy !== exp_busy) bbad++;
      if (done === 1'b1) begin
        dcnt++;
        if (dcyc < 0) begin
          dcyc = cyc; cs = C_flat; co = overflow_flag; cz = div_zero_flag;
        end
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({nm, " done_cycle"}, 200'(dcyc), 200'(expd));
    chk({nm, " done_count"}, 200'(dcnt), 200'd1);
    chk({nm, " busy_profile_errs"}, 200'(bbad), 200'd0);
    chk({nm, " C_flat"}, cs, expc);
    chk({nm, " overflow_flag"}, 200'(co), 200'(expo));
    chk({nm, " div_zero_flag"}, 200'(cz), 200'(expz));
    chk({nm, " C_flat_held"}, C_flat, expc);
  endtask

  logic [199:0] a3, e3, a4, e4, e4b, a6;
  int bad, dseen, cyc;

  initial begin
    rst_n = 1'b0; start = 1'b0;
    A_flat = rnd200(); scalar = 8'($urandom_range(0, 255));
    #1;
    chk("reset C_flat", C_flat, '0);
    chk("reset flags", {196'd0, busy, done, overflow_flag, div_zero_flag}, '0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      A_flat = rnd200(); scalar = 8'($urandom_range(0, 255));
      if (C_flat !== '0 || {busy, done, overflow_flag, div_zero_flag} !== 4'b0) bad++;
    end
    chk("idle_no_start outputs", 200'(bad), 200'd0);

    run_op("uniform 100/7", fill(8'd100), 8'd7, 1'b0, fill(8'h0E), 1'b0, 1'b0);

    a3 = '0;
    a3[0*8 +: 8] = 8'hF9; a3[1*8 +: 8] = 8'h07; a3[2*8 +: 8] = 8'hF9;
    a3[3*8 +: 8] = 8'h00; a3[4*8 +: 8] = 8'h80; a3[5*8 +: 8] = 8'h7F;
    a3[6*8 +: 8] = 8'h05;
    e3 = '0;
    e3[0*8 +: 8] = 8'h03; e3[1*8 +: 8] = 8'hFD; e3[2*8 +: 8] = 8'h03;
    e3[3*8 +: 8] = 8'h00; e3[4*8 +: 8] = 8'h40; e3[5*8 +: 8] = 8'hC1;
    e3[6*8 +: 8] = 8'hFE;
    run_op("trunc /-2", a3, 8'hFE, 1'b0, e3, 1'b0, 1'b0);
    run_op("identity /1", a3, 8'h01, 1'b0, a3, 1'b0, 1'b0);

    a4 = fill(8'h0A);  a4[12*8 +: 8] = 8'h80;
    e4 = fill(8'hF6);  e4[12*8 +: 8] = 8'h80;
    e4b = fill(8'h05); e4b[12*8 +: 8] = 8'hC0;
    run_op("overflow /-1", a4, 8'hFF, 1'b0, e4, 1'b1, 1'b0);
    run_op("after_ovf /2", a4, 8'h02, 1'b0, e4b, 1'b0, 1'b0);

    run_op("div_zero", a4, 8'h00, 1'b0, '0, 1'b0, 1'b1);
    run_op("held_start", fill(8'd100), 8'd7, 1'b1, fill(8'h0E), 1'b0, 1'b0);

    // Reset in the middle of a run that has already set overflow_flag.
    a6 = fill(8'h0A); a6[7:0] = 8'h80;
    @(negedge clk);
    A_flat = a6; scalar = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; dseen = 0;
    while (cyc < 100) begin
      if (done === 1'b1) dseen++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("midrun busy before reset", 200'(busy), 200'd1);
    chk("midrun ovf before reset", 200'(overflow_flag), 200'd1);
    rst_n = 1'b0;
    #1;
    chk("midrun reset C_flat", C_flat, '0);
    chk("midrun reset flags", {196'd0, busy, done, overflow_flag, div_zero_flag}, '0);
    repeat (3) begin
      @(posedge clk); #1;
      if (done === 1'b1) dseen++;
    end
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dseen++;
      if (busy !== 1'b0 || C_flat !== '0) bad++;
    end
    chk("midrun no_done", 200'(dseen), 200'd0);
    chk("midrun no_resume", 200'(bad), 200'd0);
    run_op("after_reset /-2", a3, 8'hFE, 1'b0, e3, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
